serial_mag_comparator: RTL and testbench
========================================

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter DIGIT, default 2, giving the bits compared per cycle; DIGIT SHALL divide WIDTH, with N = WIDTH/DIGIT.
REQ-003 The block SHALL have parameter EARLY_EXIT, default 1; when 1, the block finishes at the first unequal digit.
REQ-004 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, width 1: a request to begin a compare.
REQ-007 The block SHALL have port signed_mode, input, width 1: 1 selects two's-complement, 0 selects unsigned.
REQ-008 The block SHALL have ports a and b, input, width WIDTH each: the operands.
REQ-009 The block SHALL have port busy, output, width 1: high while a compare is in progress.
REQ-010 The block SHALL have port done, output, width 1: a one-cycle completion pulse.
REQ-011 The block SHALL have ports lt, eq and gt, output, width 1 each: the registered result.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-013 start SHALL be accepted in IDLE or DONE; on acceptance, a, b and signed_mode SHALL be captured and the FSM SHALL enter RUN.
REQ-014 start SHALL be ignored in RUN, and operand changes during RUN SHALL have no effect.
REQ-015 RUN SHALL compare DIGIT bits per cycle, MSB-first, using one digit index counter from 0 to N-1.
REQ-016 In signed mode, the most significant bit of each operand SHALL be inverted in digit 0 before the unsigned digit compare.
REQ-017 The first unequal digit SHALL fix the result; later digits SHALL NOT change it, and if all N digits are equal the result SHALL be eq.
REQ-018 With EARLY_EXIT=1, RUN SHALL exit after the deciding digit (cycle k, 1-based) or after digit N if all are equal.
REQ-019 With EARLY_EXIT=0, RUN SHALL last exactly N cycles.
REQ-020 With start sampled at edge 0, done SHALL be high in cycle k+1 (EARLY_EXIT=1) or N+1 (EARLY_EXIT=0).
REQ-021 lt, eq and gt SHALL update only on the edge entering DONE and SHALL hold until the next completion.
REQ-022 After the first completion, exactly one of lt, eq and gt SHALL be 1.
REQ-023 DONE SHALL return to IDLE after one cycle, unless start is asserted, in which case it SHALL go to RUN (back-to-back operation).

Reset
REQ-024 While reset=1, the FSM SHALL be IDLE and busy, done, lt, eq, gt, the digit counter and the decided flag SHALL all be 0, irrespective of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the compare with no done pulse.
REQ-026 The first start after reset release SHALL behave as in REQ-013.

Structure
REQ-027 Package comparator_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the result encoding constants (LT/EQ/GT).
REQ-028 Sub-module digit_cmp SHALL be a combinational DIGIT-bit unsigned compare with a sign_flip input, outputs dlt and dgt, instantiated once.
REQ-029 Operands SHALL be held in shift registers that shift left by DIGIT each RUN cycle; a parallel indexed mux is not permitted.

Verification
REQ-030 The bench SHALL cover: WIDTH=8, DIGIT=2, EARLY_EXIT=1, unsigned, a=0x35, b=0x36 -> lt=1, eq=0, gt=0, done in cycle 5.
REQ-031 The bench SHALL cover: a=0x80, b=0x7F, unsigned -> gt=1, done in cycle 2; the same operands signed -> lt=1, done in cycle 2.
REQ-032 The bench SHALL cover: a=b=0xA5, both modes -> eq=1, done in cycle 5; then EARLY_EXIT=0 with a=0x80, b=0x00 -> gt=1, done in cycle 5.
REQ-033 The bench SHALL cover: start re-pulsed in RUN with new operands -> ignored, result of the original operands; reset in cycle 2 of RUN -> all outputs 0 and no done.
REQ-034 The bench SHALL cover: start held high across DONE -> the second compare begins with no IDLE cycle, done pulses twice, and each result is correct.
REQ-035 The bench SHALL cover: WIDTH=2, DIGIT=1, unsigned, all 16 (a,b) pairs -> lt = (a<b), eq = (a==b), gt = (a>b) for every pair.

Source files
------------

// File: rtl/comparator_pkg.sv
// ----------------------------------------------------------------------------
// comparator_pkg : FSM state type and {lt,eq,gt} result encoding
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vectors are ordered {lt, eq, gt}.
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/digit_cmp.sv
// ----------------------------------------------------------------------------
// digit_cmp : combinational DIGIT-bit unsigned compare with optional MSB flip
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             sign_flip,
  output logic             dlt,
  output logic             dgt
);

  localparam logic [DIGIT-1:0] C_MSB = DIGIT'(1) << (DIGIT - 1);

  logic [DIGIT-1:0] w_mask;
  logic [DIGIT-1:0] w_fa;
  logic [DIGIT-1:0] w_fb;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_mask = sign_flip ? C_MSB : '0;
  assign w_fa   = da ^ w_mask;
  assign w_fb   = db ^ w_mask;
  assign dlt    = (w_fa < w_fb);
  assign dgt    = (w_fa > w_fb);

endmodule

`default_nettype wire

// File: rtl/serial_mag_comparator.sv
// ----------------------------------------------------------------------------
// serial_mag_comparator : MSB-first digit-serial magnitude comparator
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_mag_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int              N     = WIDTH / DIGIT;
  localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               decided_q;
  logic [2:0]         pend_q;
  logic [2:0]         res_q;

  logic               dlt, dgt;
  logic               accept;
  logic               exit_run;
  logic [2:0]         res_now;

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .da        (a_q[WIDTH-1 -: DIGIT]),
    .db        (b_q[WIDTH-1 -: DIGIT]),
    .sign_flip (sgn_q && (cnt_q == '0)),
    .dlt       (dlt),
    .dgt       (dgt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    exit_run = 1'b0;
    // Once a digit has decided, later digits cannot overturn it.
    if (decided_q)  res_now = pend_q;
    else if (dlt)   res_now = LT;
    else if (dgt)   res_now = GT;
    else            res_now = EQ;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        exit_run = (cnt_q == LAST) || (EARLY_EXIT && (dlt || dgt));
        if (exit_run) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      pend_q    <= '0;
      res_q     <= '0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      sgn_q     <= signed_mode;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      pend_q    <= EQ;
    end else if (state_q == RUN) begin
      if (exit_run) begin
        res_q <= res_now;
      end else begin
        cnt_q     <= cnt_q + CNT_W'(1);
        a_q       <= a_q << DIGIT;
        b_q       <= b_q << DIGIT;
        decided_q <= decided_q | dlt | dgt;
        pend_q    <= res_now;
      end
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign {lt, eq, gt} = res_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
// ----------------------------------------------------------------------------
// tb_serial_mag_comparator : scoreboard bench over three parameterisations
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_mag_comparator;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  typedef struct {
    int         inst;
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  logic       start0 = 1'b0, sm0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic       busy0, done0, lt0, eq0, gt0;
  logic       start1 = 1'b0, sm1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, lt1, eq1, gt1;
  logic       start2 = 1'b0, sm2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, lt2, eq2, gt2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .reset(rst), .start(start0), .signed_mode(sm0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0));

  serial_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .reset(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1));

  serial_mag_comparator #(.WIDTH(2), .DIGIT(1), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .reset(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2));

  function automatic logic [4:0] outs_of(input int inst);
    case (inst)
      0:       return {busy0, done0, lt0, eq0, gt0};
      1:       return {busy1, done1, lt1, eq1, gt1};
      default: return {busy2, done2, lt2, eq2, gt2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Pops the oldest expectation whenever any instance pulses done.
  task automatic monitor();
    exp_t e;
    logic [4:0] o;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = outs_of(i);
        if (o[3]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: inst %0d at cycle %0d, required no done", i, cyc);
          end else begin
            e = sbq.pop_front();
            if (e.inst != i || o[2:0] !== e.res || cyc != e.cyc) begin
              errors++;
              $display("FAIL result: got inst %0d res %b cycle %0d, required inst %0d res %b cycle %0d",
                       i, o[2:0], cyc, e.inst, e.res, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic issue(input int inst, input logic [7:0] av, input logic [7:0] bv,
                       input logic smv, input logic [2:0] er, input int dc);
    exp_t e;
    case (inst)
      0:       begin start0 = 1'b1; a0 = av; b0 = bv; sm0 = smv; end
      1:       begin start1 = 1'b1; a1 = av; b1 = bv; sm1 = smv; end
      default: begin start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; end
    endcase
    e.inst = inst; e.res = er; e.cyc = cyc + dc;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    chk("busy_after_start", {31'd0, outs_of(inst)[4]}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d done pulses missing, required 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int p;
    logic [2:0] er;
    int dc;

    fork
      monitor();
    join_none

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("reset_outputs", {27'd0, outs_of(i)}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Early-exit instance, directed vectors
    issue(0, 8'h35, 8'h36, 1'b0, R_LT, 5);  wait_idle();
    issue(0, 8'h80, 8'h7F, 1'b0, R_GT, 2);  wait_idle();
    issue(0, 8'h80, 8'h7F, 1'b1, R_LT, 2);  wait_idle();
    issue(0, 8'hA5, 8'hA5, 1'b0, R_EQ, 5);  wait_idle();
    chk("result_held", {29'd0, outs_of(0)[2:0]}, {29'd0, R_EQ});
    issue(0, 8'hA5, 8'hA5, 1'b1, R_EQ, 5);  wait_idle();
    issue(0, 8'h7F, 8'h80, 1'b1, R_GT, 2);  wait_idle();

    // Full-length instance always takes N cycles
    issue(1, 8'h80, 8'h00, 1'b0, R_GT, 5);  wait_idle();
    issue(1, 8'h35, 8'h36, 1'b0, R_LT, 5);  wait_idle();
    issue(1, 8'h80, 8'h7F, 1'b1, R_LT, 5);  wait_idle();

    // start re-pulsed with new operands while running
    p = cyc;
    start0 = 1'b1; a0 = 8'h35; b0 = 8'h36; sm0 = 1'b0;
    sbq.push_back('{inst: 0, res: R_LT, cyc: p + 5});
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1; a0 = 8'h36; b0 = 8'h35;
    @(negedge clk); start0 = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // start held across DONE: back-to-back compares with no IDLE cycle
    p = cyc;
    start0 = 1'b1; a0 = 8'h80; b0 = 8'h7F; sm0 = 1'b0;
    sbq.push_back('{inst: 0, res: R_GT, cyc: p + 2});
    @(negedge clk);
    @(negedge clk);
    a0 = 8'h35; b0 = 8'h36;
    sbq.push_back('{inst: 0, res: R_LT, cyc: p + 7});
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_busy", {31'd0, busy0}, 32'd1);
    wait_idle();

    // Asynchronous reset in RUN cycle 2 aborts without done
    start0 = 1'b1; a0 = 8'h35; b0 = 8'h36; sm0 = 1'b0;
    @(negedge clk); start0 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrun_reset_outputs", {27'd0, outs_of(0)}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_reset_outputs", {27'd0, outs_of(0)}, 32'd0);
    issue(0, 8'h35, 8'h36, 1'b0, R_LT, 5);  wait_idle();

    // Exhaustive 2-bit unsigned
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        er = (ai < bi) ? R_LT : ((ai == bi) ? R_EQ : R_GT);
        dc = (ai[1] != bi[1]) ? 2 : 3;
        issue(2, 8'(ai), 8'(bi), 1'b0, er, dc);
        wait_idle();
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
